// File: rtl/m_alu_shift_arbiter.sv
// Round-robin arbiter that shares one preshifter between NUM_REQ requesters
// and holds the shifted result in a one-entry, id-tagged response register.

package m_alu_shift_pkg;
    localparam logic [2:0] SH_SHL = 3'd0;
    localparam logic [2:0] SH_SHR = 3'd1;
    localparam logic [2:0] SH_ASL = 3'd2;
    localparam logic [2:0] SH_ASR = 3'd3;

    typedef struct packed {
        logic [2:0] shift_type;
        logic [4:0] amount;
    } s_shift;
endpackage

module m_alu_preshifter
    import m_alu_shift_pkg::*;
(
    input  logic [31:0] operand,
    input  s_shift      shift,
    output logic [31:0] result
);
    always_comb begin
        result = operand;
        case (shift.shift_type)
            SH_SHL, SH_ASL: result = operand << shift.amount;
            SH_SHR:         result = operand >> shift.amount;
            SH_ASR:         result = $signed(operand) >>> shift.amount;
            default:        result = operand;
        endcase
    end
endmodule

module m_alu_shift_arbiter
    import m_alu_shift_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0][31:0]  req_data,
    input  s_shift [NUM_REQ-1:0]      req_shift,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [31:0]               rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    input  logic                      rsp_ready
);
    // Handshake: a request transfers on a cycle where req_valid[i] & req_ready[i];
    // the response transfers where rsp_valid & rsp_ready. req_ready is a
    // combinational function of req_valid and rsp_ready, so requesters must
    // never derive req_valid from req_ready.

    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;

    logic            can_accept;
    logic            found;
    logic            grant_vld;
    logic [ID_W-1:0] grant_idx;
    logic [31:0]     shifted;
    int              idx;

    assign can_accept = !rsp_valid_q || rsp_ready;

    // Search from the requester after the last grant, wrapping once around.
    always_comb begin
        found     = 1'b0;
        grant_idx = last_grant_q;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

    assign grant_vld = found && can_accept && !rst;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_vld && (grant_idx == ID_W'(i));
        end
    end

    m_alu_preshifter u_preshifter (
        .operand (req_data[grant_idx]),
        .shift   (req_shift[grant_idx]),
        .result  (shifted)
    );

    // A new grant overwrites the register even while it is being drained,
    // so back-to-back results need no bubble.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        if (grant_vld) begin
            rsp_valid_d  = 1'b1;
            rsp_data_d   = shifted;
            rsp_id_d     = grant_idx;
            last_grant_d = grant_idx;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_m_alu_shift_arbiter.sv
// Scoreboard bench for m_alu_shift_arbiter with four requesters: directed
// scenarios followed by randomized traffic against a queue-based model.

module tb_m_alu_shift_arbiter;
    import m_alu_shift_pkg::*;

    localparam int N = 4;

    logic                clk;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N-1:0][31:0]  req_data;
    s_shift [N-1:0]      req_shift;
    logic [N-1:0]        req_ready;
    logic                rsp_valid;
    logic [31:0]         rsp_data;
    logic [1:0]          rsp_id;
    logic                rsp_ready;

    m_alu_shift_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_shift (req_shift),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [33:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // reference model: priority order list, granted requester rotates to the back
    int   order[$] = '{0, 1, 2, 3};
    logic m_valid  = 1'b0;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [2:0] t,
                                              input logic [4:0] a);
        longint p = 1;
        longint v;
        for (int i = 0; i < int'(a); i++) p = p * 2;
        case (t)
            3'd0, 3'd2: v = longint'(d) * p;
            3'd1:       v = longint'(d) / p;
            3'd3: begin
                v = longint'($signed(d));
                if (v < 0) v = (v - (p - 1)) / p;
                else       v = v / p;
            end
            default:    v = longint'(d);
        endcase
        return v[31:0];
    endfunction

    task automatic model_step();
        int g = -1;
        logic [3:0] exp_ready;
        if (!rst && (!m_valid || rsp_ready)) begin
            foreach (order[k]) begin
                if (g < 0 && req_valid[order[k]]) g = order[k];
            end
        end
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (rst) begin
            m_valid = 1'b0;
            order   = '{0, 1, 2, 3};
        end else if (g >= 0) begin
            exp_q.push_back({2'(g), ref_shift(req_data[g], req_shift[g].shift_type,
                                              req_shift[g].amount)});
            m_valid = 1'b1;
            while (order[0] != g) order.push_back(order.pop_front());
            order.push_back(order.pop_front());
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // driver: inputs change #1 after the edge, model sampled on the negedge
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] d, input logic [2:0] t,
                           input logic [4:0] a);
        req_data[i]             = d;
        req_shift[i].shift_type = t;
        req_shift[i].amount     = a;
    endtask

    // monitor: pops one expected entry per newly presented response
    initial begin : monitor
        logic        shown = 1'b0;
        logic [33:0] held  = '0;
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (!shown) begin
                    if (exp_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL rsp_unexpected: got id %0d data %h, expected no response",
                                 rsp_id, rsp_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_id", 32'(rsp_id), 32'(e[33:32]));
                        chk("rsp_data", rsp_data, e[31:0]);
                        held = e;
                    end
                    shown = 1'b1;
                end else begin
                    chk("rsp_hold_id", 32'(rsp_id), 32'(held[33:32]));
                    chk("rsp_hold_data", rsp_data, held[31:0]);
                end
                if (rsp_ready || rst) shown = 1'b0;
            end else begin
                shown = 1'b0;
            end
        end
    end

    initial begin : stimulus
        logic [31:0] saved;
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 32'(i) * 32'h0101_0101 + 32'h10, SH_SHL, 5'd1);

        // reset with all requesters valid
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("reset_rsp_data", rsp_data, 32'h0);
            chk("reset_rsp_id", 32'(rsp_id), 32'h0);
            chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        end
        rst = 1'b0;
        #1 chk("first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();

        // requester 1, each shift type
        req_valid = 4'b0010;
        set_req(1, 32'h8000_00F0, SH_SHL, 5'd4); tick();
        chk("shl_data", rsp_data, 32'h0000_0F00); chk("shl_id", 32'(rsp_id), 32'd1);
        set_req(1, 32'h8000_00F0, SH_SHR, 5'd4); tick();
        chk("shr_data", rsp_data, 32'h0800_000F); chk("shr_id", 32'(rsp_id), 32'd1);
        set_req(1, 32'h8000_00F0, SH_ASR, 5'd4); tick();
        chk("asr_data", rsp_data, 32'hF800_000F); chk("asr_id", 32'(rsp_id), 32'd1);
        set_req(1, 32'h8000_00F0, 3'd5, 5'd4); tick();
        chk("pass_data", rsp_data, 32'h8000_00F0); chk("pass_valid", 32'(rsp_valid), 32'd1);
        req_valid = '0;
        tick();

        // fairness after a reset pulse
        rst = 1'b1; tick(); rst = 1'b0;
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            set_req(k % N, $urandom, 3'(k % 4), 5'(k));
            #1 chk("fair_grant", 32'(req_ready), 32'(1 << (k % N)));
            if (k > 0) chk("fair_rsp_id", 32'(rsp_id), 32'((k - 1) % N));
            tick();
        end

        // back-pressure for 3 cycles
        saved = rsp_data;
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp_ready", 32'(req_ready), 32'h0);
            tick();
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd3);
            chk("bp_data", rsp_data, saved);
        end
        rsp_ready = 1'b1;
        #1 chk("bp_release", 32'(req_ready), 32'h1);
        tick();

        // drain and capture in the same edge
        req_valid = 4'b0001;
        set_req(0, 32'h1234_5678, SH_SHR, 5'd8);
        tick();
        chk("dc_valid", 32'(rsp_valid), 32'd1);
        chk("dc_data", rsp_data, 32'h0012_3456);
        chk("dc_id", 32'(rsp_id), 32'd0);
        req_valid = '0;
        tick();
        chk("drain_valid", 32'(rsp_valid), 32'd0);

        // reset while a response is held and requester 2 waits
        req_valid = 4'b0010; rsp_ready = 1'b0;
        tick();
        req_valid = 4'b0100; rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0; req_valid = 4'b0101; rsp_ready = 1'b1;
        #1 chk("mid_rst_prio", 32'(req_ready), 32'h1);
        tick();
        chk("mid_rst_id", 32'(rsp_id), 32'd0);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++)
                set_req(i, $urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 63) == 0);
            tick();
        end

        rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        repeat (3) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
